// File: rtl/jala_pkg.sv
// ---------------------------------------------------------------------------
// jala_pkg
// Shared definitions for the 16-bit JALA datapath.
//   DATA_WIDTH     : datapath and memory word width
//   REG_ADDR_WIDTH : register-file index width
//   stage4_state_e : memory-access stage states (IDLE, BUSY)
// ---------------------------------------------------------------------------
package jala_pkg;
    localparam int DATA_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } stage4_state_e;
endpackage

// File: rtl/stage4_mem_fsm.sv
// ---------------------------------------------------------------------------
// stage4_mem_fsm
// Control FSM for the memory-access stage: tracks whether a data-memory
// request is outstanding and generates the bus request/strobe signals.
// Optional feature macro: STAGE4_MEM_TIMEOUT_EN (abort after TIMEOUT_CYCLES
// BUSY cycles without an acknowledge).
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   mem_op_i   current instruction is a load or store (sampled in IDLE)
//   we_i       current instruction is a store (sampled in IDLE)
//   ack_i      memory completion strobe
//   mem_req_o  registered memory request
//   mem_we_o   registered write flag of the request
//   stall_o    hold upstream stages (state == BUSY)
//   fault_o    one-cycle pulse on timeout abort (0 without the macro)
// ---------------------------------------------------------------------------
module stage4_mem_fsm
    import jala_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_op_i,
    input  logic we_i,
    input  logic ack_i,
    output logic mem_req_o,
    output logic mem_we_o,
    output logic stall_o,
    output logic fault_o
);

    stage4_state_e state_q;
    logic          mem_req_q;
    logic          mem_we_q;

`ifdef STAGE4_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
    logic             timeout_hit;

    // The counter holds the number of BUSY cycles already completed, so the
    // abort fires on the TIMEOUT_CYCLES-th BUSY edge without an ack.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fault_o     = fault_q;
`else
    assign fault_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef STAGE4_MEM_TIMEOUT_EN
            cnt_q     <= '0;
            fault_q   <= 1'b0;
`endif
        end else begin
`ifdef STAGE4_MEM_TIMEOUT_EN
            fault_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_op_i) begin
                        state_q   <= BUSY;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= we_i;
`ifdef STAGE4_MEM_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                BUSY: begin
                    // An ack on the same edge as the timeout takes priority.
                    if (ack_i) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
`ifdef STAGE4_MEM_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o = mem_req_q;
    assign mem_we_o  = mem_we_q;
    assign stall_o   = (state_q == BUSY);

endmodule

// File: rtl/stage4_mem_access.sv
// ---------------------------------------------------------------------------
// stage4_mem_access
// JALA pipeline stage 4: performs at most one data-memory load/store per
// instruction over a req/ack bus and presents write-back data.
// Optional feature macro: STAGE4_MEM_TIMEOUT_EN (bus timeout, MemFault).
// Ports:
//   CLK, Reset                         clock, async active-high reset
//   ResIn, StoreData                   stage-3 result / address, store data
//   MemRead, MemWrite, MemToReg        memory control from stage 3
//   RegWriteIn, DestRegIn              write-back control from stage 3
//   MemReq, MemWe, MemAddr, MemWData   registered memory request bus
//   MemRData, MemAck                   memory response
//   WBData, RegWriteOut, DestRegOut    registered write-back outputs
//   Stall                              hold upstream while access pending
//   MemFault                           one-cycle timeout abort pulse
// ---------------------------------------------------------------------------
module stage4_mem_access
    import jala_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [DATA_WIDTH-1:0]     ResIn,
    input  logic [DATA_WIDTH-1:0]     StoreData,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      MemToReg,
    input  logic                      RegWriteIn,
    input  logic [REG_ADDR_WIDTH-1:0] DestRegIn,
    output logic                      MemReq,
    output logic                      MemWe,
    output logic [DATA_WIDTH-1:0]     MemAddr,
    output logic [DATA_WIDTH-1:0]     MemWData,
    input  logic [DATA_WIDTH-1:0]     MemRData,
    input  logic                      MemAck,
    output logic [DATA_WIDTH-1:0]     WBData,
    output logic                      RegWriteOut,
    output logic [REG_ADDR_WIDTH-1:0] DestRegOut,
    output logic                      Stall,
    output logic                      MemFault
);

    logic [DATA_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     wb_q;
    logic [DATA_WIDTH-1:0]     wb_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q;
    logic                      mem_to_reg_q;
    logic                      reg_write_lat_q;
    logic                      reg_write_out_q;
    logic                      mem_op;

    assign mem_op = MemRead | MemWrite;

    stage4_mem_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk_i    (CLK),
        .rst_i    (Reset),
        .mem_op_i (mem_op),
        .we_i     (MemWrite),   // store wins when both flags are set
        .ack_i    (MemAck),
        .mem_req_o(MemReq),
        .mem_we_o (MemWe),
        .stall_o  (Stall),
        .fault_o  (MemFault)
    );

    // Load write-back mux: memory data or the latched address (ALU result).
    assign wb_d = mem_to_reg_q ? MemRData : addr_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            addr_q          <= '0;
            wdata_q         <= '0;
            wb_q            <= '0;
            dest_q          <= '0;
            mem_to_reg_q    <= 1'b0;
            reg_write_lat_q <= 1'b0;
            reg_write_out_q <= 1'b0;
        end else if (!Stall) begin
            dest_q <= DestRegIn;
            if (mem_op) begin
                addr_q          <= ResIn;
                wdata_q         <= StoreData;
                mem_to_reg_q    <= MemToReg;
                reg_write_lat_q <= RegWriteIn;
                reg_write_out_q <= 1'b0;
            end else begin
                wb_q            <= ResIn;
                reg_write_out_q <= RegWriteIn;
            end
        end else if (MemAck && !MemWe) begin
            wb_q            <= wb_d;
            reg_write_out_q <= reg_write_lat_q;
        end else begin
            // Waiting, store completion or timeout abort: no register write.
            reg_write_out_q <= 1'b0;
        end
    end

    assign MemAddr     = addr_q;
    assign MemWData    = wdata_q;
    assign WBData      = wb_q;
    assign DestRegOut  = dest_q;
    assign RegWriteOut = reg_write_out_q;

endmodule

// File: tb/tb_stage4_mem_access.sv
// ---------------------------------------------------------------------------
// tb_stage4_mem_access
// Directed scenarios with literal expectations, then randomized traffic; a
// transaction-level model predicts every output and is compared each cycle.
// ---------------------------------------------------------------------------
module tb_stage4_mem_access;

`ifdef STAGE4_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] ResIn = '0, StoreData = '0, MemRData = '0;
    logic        MemRead = 0, MemWrite = 0, MemToReg = 0, RegWriteIn = 0, MemAck = 0;
    logic [3:0]  DestRegIn = '0;
    logic        MemReq, MemWe, RegWriteOut, Stall, MemFault;
    logic [15:0] MemAddr, MemWData, WBData;
    logic [3:0]  DestRegOut;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    stage4_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .Reset(Reset), .ResIn(ResIn), .StoreData(StoreData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .RegWriteIn(RegWriteIn), .DestRegIn(DestRegIn),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemAck(MemAck), .WBData(WBData),
        .RegWriteOut(RegWriteOut), .DestRegOut(DestRegOut),
        .Stall(Stall), .MemFault(MemFault)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One outstanding access at most; "pending" describes it.
    logic [15:0] e_wb = '0, e_addr = '0, e_wdata = '0;
    logic [3:0]  e_dest = '0;
    logic        e_req = 0, e_we = 0, e_rw = 0, e_fault = 0, pending = 0;
    logic        p_load_to_reg = 0, p_rw = 0;
    int          p_waited = 0;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            e_wb = '0; e_addr = '0; e_wdata = '0; e_dest = '0;
            e_req = 0; e_we = 0; e_rw = 0; e_fault = 0; pending = 0;
        end else begin
            e_fault = 0;
            if (!pending) begin
                e_dest = DestRegIn;
                if (MemRead || MemWrite) begin
                    pending = 1; p_waited = 0;
                    e_req = 1; e_we = MemWrite;
                    e_addr = ResIn; e_wdata = StoreData;
                    p_load_to_reg = MemToReg; p_rw = RegWriteIn;
                    e_rw = 0;
                end else begin
                    e_wb = ResIn; e_rw = RegWriteIn;
                end
            end else begin
                p_waited++;
                if (MemAck) begin
                    pending = 0; e_req = 0;
                    if (e_we) e_rw = 0;
                    else begin
                        e_wb = p_load_to_reg ? MemRData : e_addr;
                        e_rw = p_rw;
                    end
                end else if (TO_EN && p_waited == TO) begin
                    pending = 0; e_req = 0; e_rw = 0; e_fault = 1;
                end else begin
                    e_rw = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("m_MemReq", MemReq, e_req);
            cmp("m_MemWe", MemWe, e_we);
            cmp("m_MemAddr", MemAddr, e_addr);
            cmp("m_MemWData", MemWData, e_wdata);
            cmp("m_WBData", WBData, e_wb);
            cmp("m_RegWriteOut", RegWriteOut, e_rw);
            cmp("m_DestRegOut", DestRegOut, e_dest);
            cmp("m_Stall", Stall, pending);
            cmp("m_MemFault", MemFault, e_fault);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic set_nop();
        MemRead = 0; MemWrite = 0; MemToReg = 0; RegWriteIn = 0;
        ResIn = '0; StoreData = '0; DestRegIn = '0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [15:0] a, input logic [15:0] d, input logic [3:0] dst);
        MemRead = rd; MemWrite = wr; MemToReg = m2r; RegWriteIn = rw;
        ResIn = a; StoreData = d; DestRegIn = dst;
    endtask

    initial begin
        #1 Reset = 1;
        tick(); tick();
        cmp("rst_MemReq", MemReq, 0);
        cmp("rst_WBData", WBData, 0);
        cmp("rst_Stall", Stall, 0);
        cmp("rst_MemAddr", MemAddr, 0);
        #2 Reset = 0;
        chk_en = 1;
        tick();

        // ALU op: 1-cycle latency, no stall
        drive(0, 0, 0, 1, 16'h1234, 16'h0, 4'd3);
        tick();
        set_nop();
        cmp("alu_WBData", WBData, 16'h1234);
        cmp("alu_RegWriteOut", RegWriteOut, 1);
        cmp("alu_DestRegOut", DestRegOut, 3);
        cmp("alu_Stall", Stall, 0);

        // Load, ack after 3 cycles
        drive(1, 0, 1, 1, 16'h0040, 16'h0, 4'd5);
        tick();
        set_nop();
        cmp("ld_MemReq", MemReq, 1);
        cmp("ld_RegWriteOut_bubble", RegWriteOut, 0);
        for (int i = 0; i < 3; i++) begin
            cmp("ld_MemAddr_hold", MemAddr, 16'h0040);
            cmp("ld_Stall", Stall, 1);
            if (i == 2) begin MemAck = 1; MemRData = 16'hBEEF; end
            tick();
        end
        MemAck = 0;
        cmp("ld_WBData", WBData, 16'hBEEF);
        cmp("ld_RegWriteOut", RegWriteOut, 1);
        cmp("ld_DestRegOut", DestRegOut, 5);
        cmp("ld_Stall_done", Stall, 0);

        // Store, ack on first BUSY cycle (follows immediately, WBData held)
        drive(0, 1, 0, 1, 16'h0010, 16'hA5A5, 4'd2);
        tick();
        set_nop();
        cmp("st_MemWe", MemWe, 1);
        cmp("st_MemWData", MemWData, 16'hA5A5);
        cmp("st_Stall", Stall, 1);
        MemAck = 1;
        tick();
        MemAck = 0;
        cmp("st_Stall_done", Stall, 0);
        cmp("st_RegWriteOut", RegWriteOut, 0);
        cmp("st_WBData_held", WBData, 16'hBEEF);

        // MemRead and MemWrite both set: store
        drive(1, 1, 1, 1, 16'h0022, 16'h3333, 4'd1);
        tick();
        set_nop();
        cmp("both_MemWe", MemWe, 1);
        MemAck = 1; MemRData = 16'h9999;
        tick();
        MemAck = 0;
        cmp("both_RegWriteOut", RegWriteOut, 0);
        cmp("both_WBData_held", WBData, 16'hBEEF);

        // Reset mid-access, late ack ignored
        drive(1, 0, 1, 1, 16'h0077, 16'h0, 4'd6);
        tick();
        set_nop();
        #2 Reset = 1;
        #1;
        cmp("rstmid_MemReq", MemReq, 0);
        cmp("rstmid_Stall", Stall, 0);
        @(posedge CLK); #3 Reset = 0;
        MemAck = 1; MemRData = 16'h1111;
        tick();
        MemAck = 0;
        cmp("late_ack_WBData", WBData, 0);
        cmp("late_ack_RegWriteOut", RegWriteOut, 0);
        cmp("late_ack_MemReq", MemReq, 0);

        if (TO_EN) begin
            // No ack: fault after TO BUSY cycles
            drive(1, 0, 1, 1, 16'h0050, 16'h0, 4'd7);
            tick();
            set_nop();
            for (int i = 0; i < TO - 1; i++) begin
                tick();
                cmp("to_nofault_yet", MemFault, 0);
            end
            tick();
            cmp("to_MemFault", MemFault, 1);
            cmp("to_MemReq", MemReq, 0);
            cmp("to_Stall", Stall, 0);
            cmp("to_RegWriteOut", RegWriteOut, 0);
            tick();
            cmp("to_MemFault_pulse", MemFault, 0);
            // Ack on the last allowed cycle wins
            drive(1, 0, 1, 1, 16'h0060, 16'h0, 4'd8);
            tick();
            set_nop();
            for (int i = 0; i < TO - 1; i++) tick();
            MemAck = 1; MemRData = 16'h4321;
            tick();
            MemAck = 0;
            cmp("toack_MemFault", MemFault, 0);
            cmp("toack_WBData", WBData, 16'h4321);
            cmp("toack_RegWriteOut", RegWriteOut, 1);
        end

        // Randomized traffic; inputs randomized even while stalled
        for (int n = 0; n < 3000; n++) begin
            int ack_pct;
            ack_pct = (n < 1500) ? 35 : 15;
            MemRead    = ($urandom_range(0, 99) < 25);
            MemWrite   = ($urandom_range(0, 99) < 20);
            MemToReg   = $urandom_range(0, 1);
            RegWriteIn = $urandom_range(0, 1);
            ResIn      = 16'($urandom);
            StoreData  = 16'($urandom);
            DestRegIn  = 4'($urandom);
            MemRData   = 16'($urandom);
            MemAck     = ($urandom_range(0, 99) < ack_pct);
            if ($urandom_range(0, 399) == 0) begin
                #2 Reset = 1;
                @(posedge CLK); #3 Reset = 0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
